// File: rtl/sha256_msg_ctrl.sv
// sha256_msg_ctrl
// Turns a stream of big-endian 32-bit message words into padded 512-bit SHA-256
// blocks. It commands a compression core (core_init/core_next) and returns the
// final digest with a valid/ready handshake.
//
// Ports
//   clk, reset          : single clock, asynchronous active-high reset
//   in_valid/in_ready   : message word handshake; in_data holds bytes MSB-first
//   in_last, in_nbytes  : last word flag, valid bytes minus one in that word
//   core_init/core_next : one-cycle command pulses to the core
//   core_block          : padded block, word 0 in [511:480]
//   core_ready          : core idle
//   core_digest(_valid) : core result
//   out_valid/out_ready : final digest handshake, out_digest held while valid
module sha256_msg_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [31:0]    in_data,
    input  logic           in_last,
    input  logic [1:0]     in_nbytes,
    output logic           core_init,
    output logic           core_next,
    output logic [511:0]   core_block,
    input  logic           core_ready,
    input  logic [255:0]   core_digest,
    input  logic           core_digest_valid,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [255:0]   out_digest
);

    typedef enum logic [2:0] {IDLE, FILL, PAD, ISSUE, WAIT, XBLK, OUT} state_t;

    state_t             state_r;
    logic [511:0]       core_block_r;
    logic [3:0]         widx_r;
    logic [6:0]         p_r;          // next free byte position in the block, 0..64
    logic [CNT_W-1:0]   byte_cnt_r;
    logic               first_r;      // next command is the first block of the message
    logic               final_r;      // block being issued is the last one
    logic               extra_r;      // an extra length block must follow
    logic               extra80_r;    // extra block also carries the 0x80 marker
    logic               skip_r;       // ignore core_ready the cycle after a command
    logic               in_ready_r;
    logic               core_init_r;
    logic               core_next_r;
    logic               out_valid_r;
    logic [255:0]       out_digest_r;

    logic               accept_s;
    logic [2:0]         add_s;
    logic [31:0]        word_s;
    logic [6:0]         p_next_s;
    logic [63:0]        len_s;

    // Keep only the valid MSB-aligned bytes of the final word.
    function automatic logic [31:0] mask_last(input logic [31:0] w, input logic [1:0] nb);
        logic [31:0] m;
        case (nb)
            2'd0:    m = {w[31:24], 24'h000000};
            2'd1:    m = {w[31:16], 16'h0000};
            2'd2:    m = {w[31:8], 8'h00};
            default: m = w;
        endcase
        return m;
    endfunction

    // Saturating byte counter add; overflow pins the count instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [2:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {{(CNT_W-2){1'b0}}, b};
        return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

    // Message length in bits, zero-extended to the 64-bit length field.
    function automatic logic [63:0] bit_len(input logic [CNT_W-1:0] c);
        logic [63:0] l;
        l = {{(64-CNT_W){1'b0}}, c};
        return {l[60:0], 3'b000};
    endfunction

    // Input word handling: accept strobe, byte increment and masked word.
    always_comb begin
        accept_s = in_valid && in_ready_r;
        if (in_last) begin
            add_s  = {1'b0, in_nbytes} + 3'd1;
            word_s = mask_last(in_data, in_nbytes);
        end else begin
            add_s  = 3'd4;
            word_s = in_data;
        end
        p_next_s = {1'b0, widx_r, 2'b00} + {4'b0000, add_s};
        len_s    = bit_len(byte_cnt_r);
    end

    // Control FSM with all outputs registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            core_block_r <= 512'd0;
            widx_r       <= 4'd0;
            p_r          <= 7'd0;
            byte_cnt_r   <= {CNT_W{1'b0}};
            first_r      <= 1'b0;
            final_r      <= 1'b0;
            extra_r      <= 1'b0;
            extra80_r    <= 1'b0;
            skip_r       <= 1'b0;
            in_ready_r   <= 1'b0;
            core_init_r  <= 1'b0;
            core_next_r  <= 1'b0;
            out_valid_r  <= 1'b0;
            out_digest_r <= 256'd0;
        end else begin
            core_init_r <= 1'b0;
            core_next_r <= 1'b0;
            case (state_r)
                IDLE, FILL: begin
                    in_ready_r <= 1'b1;
                    if (state_r == IDLE) begin
                        first_r <= 1'b1;
                    end
                    if (accept_s) begin
                        core_block_r[{4'd15 - widx_r, 5'd0} +: 32] <= word_s;
                        byte_cnt_r <= sat_add(byte_cnt_r, add_s);
                        widx_r     <= widx_r + 4'd1;
                        if (in_last) begin
                            p_r        <= p_next_s;
                            in_ready_r <= 1'b0;
                            state_r    <= PAD;
                        end else if (widx_r == 4'd15) begin
                            final_r    <= 1'b0;
                            extra_r    <= 1'b0;
                            in_ready_r <= 1'b0;
                            state_r    <= ISSUE;
                        end else begin
                            state_r    <= FILL;
                        end
                    end
                end
                PAD: begin
                    if (p_r <= 7'd55) begin
                        core_block_r[{6'd63 - p_r[5:0], 3'b000} +: 8] <= 8'h80;
                        core_block_r[63:0] <= len_s;
                        final_r   <= 1'b1;
                        extra_r   <= 1'b0;
                        extra80_r <= 1'b0;
                    end else if (p_r <= 7'd63) begin
                        core_block_r[{6'd63 - p_r[5:0], 3'b000} +: 8] <= 8'h80;
                        final_r   <= 1'b0;
                        extra_r   <= 1'b1;
                        extra80_r <= 1'b0;
                    end else begin
                        // Full block: marker moves to byte 0 of the extra block.
                        final_r   <= 1'b0;
                        extra_r   <= 1'b1;
                        extra80_r <= 1'b1;
                    end
                    state_r <= ISSUE;
                end
                ISSUE: begin
                    if (core_ready) begin
                        if (first_r) begin
                            core_init_r <= 1'b1;
                        end else begin
                            core_next_r <= 1'b1;
                        end
                        first_r <= 1'b0;
                        skip_r  <= 1'b1;
                        state_r <= WAIT;
                    end
                end
                WAIT: begin
                    // The core may still report ready in the cycle after the command.
                    if (skip_r) begin
                        skip_r <= 1'b0;
                    end else if (core_ready) begin
                        if (extra_r) begin
                            state_r <= XBLK;
                        end else if (!final_r) begin
                            widx_r       <= 4'd0;
                            core_block_r <= 512'd0;
                            in_ready_r   <= 1'b1;
                            state_r      <= FILL;
                        end else begin
                            state_r <= OUT;
                        end
                    end
                end
                XBLK: begin
                    core_block_r <= {(extra80_r ? 8'h80 : 8'h00), 440'd0, len_s};
                    extra_r   <= 1'b0;
                    extra80_r <= 1'b0;
                    final_r   <= 1'b1;
                    state_r   <= ISSUE;
                end
                OUT: begin
                    if (out_valid_r) begin
                        if (out_ready) begin
                            out_valid_r  <= 1'b0;
                            byte_cnt_r   <= {CNT_W{1'b0}};
                            widx_r       <= 4'd0;
                            p_r          <= 7'd0;
                            core_block_r <= 512'd0;
                            final_r      <= 1'b0;
                            first_r      <= 1'b1;
                            in_ready_r   <= 1'b1;
                            state_r      <= IDLE;
                        end
                    end else if (core_digest_valid) begin
                        out_digest_r <= core_digest;
                        out_valid_r  <= 1'b1;
                    end
                end
                default: begin
                    in_ready_r <= 1'b0;
                    state_r    <= IDLE;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_r;
    assign core_init  = core_init_r;
    assign core_next  = core_next_r;
    assign core_block = core_block_r;
    assign out_valid  = out_valid_r;
    assign out_digest = out_digest_r;

endmodule

// File: doc/sha256_msg_ctrl.md
SHA256_MSG_CTRL -- requirements
Module: sha256_msg_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 32: width of the internal message byte counter. Messages are limited to 2^CNT_W-1 bytes, and the length field is zero-extended to 64 bits.
REQ-002 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-003 SHALL have port reset, input, 1: reset is asynchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1: message word valid.
REQ-005 SHALL have port in_ready, output, 1: controller accepts word; transfer when in_valid&&in_ready.
REQ-006 SHALL have port in_data, input, 32: message word, big-endian; first byte is in bits [31:24].
REQ-007 SHALL have port in_last, input, 1: word is the final word of the message.
REQ-008 SHALL have port in_nbytes, input, 2: valid bytes minus 1 in the final word (MSB-aligned); ignored unless in_last.
REQ-009 SHALL have port core_init, output, 1: one-cycle pulse starting the first block of a message.
REQ-010 SHALL have port core_next, output, 1: one-cycle pulse for each subsequent block.
REQ-011 SHALL have port core_block, output, 512: padded block; word 0 is in [511:480]; stable from the command pulse until the core returns ready.
REQ-012 SHALL have port core_ready, input, 1: core idle.
REQ-013 SHALL have port core_digest, input, 256: core result.
REQ-014 SHALL have port core_digest_valid, input, 1: core_digest valid.
REQ-015 SHALL have port out_valid, output, 1: final digest available.
REQ-016 SHALL have port out_ready, input, 1: consumer accepts digest.
REQ-017 SHALL have port out_digest, output, 256: final digest; stable while out_valid.

Function
REQ-018 SHALL implement the states IDLE, FILL, PAD, ISSUE, WAIT, XBLK and OUT.
- IDLE: in_ready=1; first accepted word goes to buffer word 0 and the FSM moves to FILL (or PAD if in_last).
REQ-019 SHALL, in FILL, assert in_ready=1 and store each accepted word at buffer index widx; widx and the byte count increment per word.
REQ-020 SHALL deassert in_ready the cycle after word 15 is accepted without in_last, and go to ISSUE; the message is then non-final.
REQ-021 SHALL, on an accepted in_last word, count in_nbytes+1 bytes, zero the invalid low bytes of the word, and go to PAD.
REQ-022 SHALL insert padding in PAD according to the byte position p of the next free byte in the block (0..64):
- p<=55: byte p=0x80, zeros to byte 55, 64-bit bit-length (bytes*8) in bytes 56..63; this is the final block.
- 56<=p<=63: byte p=0x80, zeros to the end; an extra block follows.
- p=64: block issued unchanged; the extra block has byte 0=0x80.
REQ-023 SHALL, in ISSUE, wait for core_ready=1 and then pulse core_init for one cycle if this is the first block of the message, otherwise pulse core_next; it SHALL never assert both.
REQ-024 SHALL, in WAIT, ignore core_ready for the cycle after the pulse, then wait for core_ready=1, then choose the next state:
- XBLK if an extra block is pending;
- FILL (widx=0, buffer cleared) if the message is non-final;
- OUT if the final block is done.
REQ-025 SHALL, in XBLK, build the extra block: zeros, 0x80 at byte 0 only for the p=64 case, length in bytes 56..63; then go to ISSUE.
REQ-026 SHALL, on entering OUT, latch core_digest into out_digest once core_digest_valid=1, then assert out_valid; out_valid and out_digest hold until out_ready=1.
REQ-027 SHALL, on the cycle out_valid&&out_ready, clear out_valid, clear the counters and go to IDLE.
REQ-028 SHALL hold in_ready=0 in every state other than IDLE and FILL.
REQ-029 SHALL make the byte counter saturate at 2^CNT_W-1; overflow is a usage error and the block SHALL NOT hang on it.
REQ-030 SHALL give a stall on core_ready (held 0) no timeout; the FSM waits indefinitely.

Reset
REQ-031 SHALL, on reset asserted at any time including mid-block, immediately force the FSM to IDLE and set core_init=0, core_next=0, core_block=0, out_valid=0, out_digest=0, counters=0 and in_ready=0 while reset is high.
REQ-032 SHALL drive in_ready=1 on the first clock edge after reset deasserts.

Verification
REQ-033 SHALL cover single word 0x61626300, in_last, in_nbytes=2 ("abc") -> one core_init, core_block=61626380, zeros, 00000018; out_digest=ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.
REQ-034 SHALL cover the 56-byte "abcdbcdecdef...nopq" (p=56) -> init, then next with an extra block ending 000001c0; digest=248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1.
REQ-035 SHALL cover a 64-byte message (16 words, last with nbytes=3) -> second block = 80000000, zeros, 00000200; exactly one init and one next.
REQ-036 SHALL cover out_ready held 0 for 20 cycles after out_valid -> out_valid and out_digest stable; in_ready=0 throughout; IDLE one cycle after out_ready=1.
REQ-037 SHALL cover reset asserted after word 7 of a block -> all outputs 0 within the same cycle; a following "abc" message produces the REQ-033 digest with core_init, not core_next.
REQ-038 SHALL cover core_ready held 0 for 10 cycles in ISSUE -> no command pulse until core_ready=1; exactly one pulse afterwards.
